// File: rtl/find_max.sv
// find_max: streaming second-largest finder.
//   A start pulse latches a beat count. Each accepted beat offers up to three
//   8-bit operands (enabled by select). Each enabled operand is transformed by
//   the beat's instruction and merged into a running top-2 tracker. When the
//   operation completes, the tracker's second-largest value is registered on
//   second_maximum and held until the next operation completes.
//
// Build option:
//   FIND_MAX_DISTINCT_EN  defined   -> tracker keeps distinct values only
//                         undefined -> multiset semantics (duplicates count)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous reset, active-HIGH (asserted when 1)
//   start           begin a new operation, latch count (overrides valid)
//   valid           beat strobe for data_A/B/C, select, instruction
//   data_A/B/C      unsigned operands
//   instruction     [1:0] op: 00 pass, 01 invert, 10 add k, 11 shift right k[2:0]
//                   [7:2] k
//   count           beats in the operation (0..7), sampled with start
//   select          operand enables: bit0=A, bit1=B, bit2=C
//   second_maximum  registered result of the last completed operation

module find_max (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       valid,
  input  logic [7:0] data_A,
  input  logic [7:0] data_B,
  input  logic [7:0] data_C,
  input  logic [7:0] instruction,
  input  logic [2:0] count,
  input  logic [2:0] select,
  output logic [7:0] second_maximum
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state,      state_nxt;
  logic [DW-1:0] max1,       max1_nxt;
  logic [DW-1:0] max2,       max2_nxt;
  logic [CW-1:0] beats_left, beats_nxt;
  logic [DW-1:0] result_nxt;
  logic [2*DW-1:0] merged;

  // Apply the per-beat instruction to one operand.
  function automatic logic [DW-1:0] xform(input logic [DW-1:0] x,
                                          input logic [7:0]    ins);
    logic [5:0] k;
    k = ins[7:2];
    case (ins[1:0])
      2'b00:   return x;
      2'b01:   return ~x;
      2'b10:   return x + DW'(k);
      default: return x >> k[2:0];
    endcase
  endfunction

  // Insert one candidate into the {largest, second} pair.
  function automatic logic [2*DW-1:0] top2_insert(input logic [DW-1:0] m1,
                                                  input logic [DW-1:0] m2,
                                                  input logic [DW-1:0] x);
`ifdef FIND_MAX_DISTINCT_EN
    if (x > m1)                  return {x, m1};
    else if (x != m1 && x > m2)  return {m1, x};
    else                         return {m1, m2};
`else
    // x == m1 falls through to the second test, so duplicates fill max2.
    if (x > m1)       return {x, m1};
    else if (x > m2)  return {m1, x};
    else              return {m1, m2};
`endif
  endfunction

  // Merge up to three enabled, transformed operands into the tracker.
  always_comb begin
    merged = {max1, max2};
    if (select[0]) merged = top2_insert(merged[2*DW-1:DW], merged[DW-1:0],
                                        xform(data_A, instruction));
    if (select[1]) merged = top2_insert(merged[2*DW-1:DW], merged[DW-1:0],
                                        xform(data_B, instruction));
    if (select[2]) merged = top2_insert(merged[2*DW-1:DW], merged[DW-1:0],
                                        xform(data_C, instruction));
  end

  // Next-state and next-register values.
  always_comb begin
    state_nxt  = state;
    max1_nxt   = max1;
    max2_nxt   = max2;
    beats_nxt  = beats_left;
    result_nxt = second_maximum;

    // A completed operation publishes its result even if a new one starts now.
    if (state == DONE) result_nxt = max2;

    if (start) begin
      max1_nxt  = '0;
      max2_nxt  = '0;
      beats_nxt = count;
      state_nxt = (count == '0) ? DONE : RUN;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        RUN: begin
          if (valid) begin
            max1_nxt  = merged[2*DW-1:DW];
            max2_nxt  = merged[DW-1:0];
            beats_nxt = beats_left - CW'(1);
            if (beats_left == CW'(1)) state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state          <= IDLE;
      max1           <= '0;
      max2           <= '0;
      beats_left     <= '0;
      second_maximum <= '0;
    end else begin
      state          <= state_nxt;
      max1           <= max1_nxt;
      max2           <= max2_nxt;
      beats_left     <= beats_nxt;
      second_maximum <= result_nxt;
    end
  end

endmodule

// File: tb/tb_find_max.sv
// tb_find_max: directed stimulus with a scoreboard. The driver pushes each
// expected result with the cycle it must appear; a negedge monitor pops and
// compares on that cycle and checks that the output holds on every other cycle.

module tb_find_max;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       valid;
  logic [7:0] data_A, data_B, data_C;
  logic [7:0] instruction;
  logic [2:0] count;
  logic [2:0] select;
  logic [7:0] second_maximum;

  typedef struct {
    logic [7:0] val;
    int         due;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;
  logic [7:0] cur_exp = 8'h00;
  string      cur_name = "reset";

  find_max dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .valid          (valid),
    .data_A         (data_A),
    .data_B         (data_B),
    .data_C         (data_C),
    .instruction    (instruction),
    .count          (count),
    .select         (select),
    .second_maximum (second_maximum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare scheduled results, otherwise require the output to hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        exp_t s;
        s = sb.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s: result not taken at cycle %0d (now %0d), required 0x%02h",
                 s.name, s.due, cyc, s.val);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t s;
        s = sb.pop_front();
        cur_exp  = s.val;
        cur_name = s.name;
        vectors++;
        if (second_maximum !== cur_exp) begin
          miscompares++;
          $display("FAIL %s: second_maximum=0x%02h required 0x%02h (cycle %0d)",
                   cur_name, second_maximum, cur_exp, cyc);
        end
      end else begin
        vectors++;
        if (second_maximum !== cur_exp) begin
          miscompares++;
          $display("FAIL hold after %s: second_maximum=0x%02h required 0x%02h (cycle %0d)",
                   cur_name, second_maximum, cur_exp, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_exp(input logic [7:0] v, input int due, input string name);
    exp_t e;
    e.val  = v;
    e.due  = due;
    e.name = name;
    sb.push_back(e);
  endtask

  // Called right after the edge that accepted the final beat (or start with count 0).
  task automatic expect_done(input logic [7:0] v, input string name);
    push_exp(v, cyc + 1, name);
  endtask

  task automatic op_start(input logic [2:0] c);
    start = 1'b1;
    count = c;
    valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [2:0] sel, input logic [7:0] ins);
    valid       = 1'b1;
    data_A      = a;
    data_B      = b;
    data_C      = c;
    select      = sel;
    instruction = ins;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_dup;
    logic [7:0] exp_rep;
    rst_n = 1'b1; start = 1'b0; valid = 1'b0;
    data_A = '0; data_B = '0; data_C = '0;
    instruction = '0; count = '0; select = '0;

    // Reset for two cycles.
    idle(2);
    push_exp(8'h00, cyc, "reset");
    mon_en = 1'b1;
    rst_n  = 1'b0;

    // Beats without start are ignored in IDLE.
    beat(8'hAA, 8'hBB, 8'hCC, 3'b111, 8'h00);
    beat(8'h11, 8'h22, 8'h33, 3'b111, 8'h00);
    idle(2);

    // Single beat, pass-through; a beat in the DONE cycle is ignored.
    op_start(3'd1);
    beat(8'h10, 8'h50, 8'h30, 3'b111, 8'h00);
    expect_done(8'h30, "one_beat");
    beat(8'hFF, 8'hFE, 8'hFD, 3'b111, 8'h00);
    idle(2);

    // Two beats with a gap between them.
    op_start(3'd2);
    beat(8'h05, 8'h07, 8'h01, 3'b111, 8'h00);
    idle(3);
    beat(8'h09, 8'h02, 8'h08, 3'b111, 8'h00);
    expect_done(8'h08, "two_beats_gap");
    idle(2);

    // Invert with select=011, then same with select=000.
    op_start(3'd1);
    beat(8'hF0, 8'h0F, 8'h80, 3'b011, 8'h01);
    expect_done(8'h0F, "invert_sel011");
    idle(2);
    op_start(3'd1);
    beat(8'hF0, 8'h0F, 8'h80, 3'b000, 8'h01);
    expect_done(8'h00, "sel000");
    idle(2);

    // Duplicate maximum within one beat.
`ifdef FIND_MAX_DISTINCT_EN
    exp_rep = 8'h10;
`else
    exp_rep = 8'h40;
`endif
    op_start(3'd1);
    beat(8'h40, 8'h40, 8'h10, 3'b111, 8'h00);
    expect_done(exp_rep, "dup_in_beat");
    idle(2);

    // Restart after 1 of 3 beats, then count=0.
    op_start(3'd3);
    beat(8'h11, 8'h22, 8'h33, 3'b111, 8'h00);
    idle(1);
    op_start(3'd1);
    beat(8'h01, 8'h02, 8'h03, 3'b111, 8'h00);
    expect_done(8'h02, "restart");
    idle(2);
    op_start(3'd0);
    expect_done(8'h00, "count0");
    idle(2);

    // Add k=1: FF->00, 10->11, 20->21.
    op_start(3'd1);
    beat(8'hFF, 8'h10, 8'h20, 3'b111, 8'h06);
    expect_done(8'h11, "add_k1_wrap");
    idle(1);

    // Shift k=2: 80->20, 40->10, FC->3F.
    op_start(3'd1);
    beat(8'h80, 8'h40, 8'hFC, 3'b111, 8'h0B);
    expect_done(8'h20, "shr_k2");
    idle(1);

    // Shift k=9 uses k[2:0]=1: 80->40, 40->20, 02->01.
    op_start(3'd1);
    beat(8'h80, 8'h40, 8'h02, 3'b111, 8'h27);
    expect_done(8'h20, "shr_k9");
    idle(1);

    // Only one candidate in total.
    op_start(3'd1);
    beat(8'h55, 8'hAA, 8'hBB, 3'b001, 8'h00);
    expect_done(8'h00, "single_cand");
    idle(1);

    // Equal values across beats.
`ifdef FIND_MAX_DISTINCT_EN
    exp_dup = 8'h00;
`else
    exp_dup = 8'h09;
`endif
    op_start(3'd2);
    beat(8'h09, 8'hEE, 8'hEE, 3'b001, 8'h00);
    beat(8'h09, 8'hEE, 8'hEE, 3'b001, 8'h00);
    expect_done(exp_dup, "dup_across_beats");
    idle(2);

    // start and valid together: the beat is dropped.
    start = 1'b1; count = 3'd1; valid = 1'b1;
    data_A = 8'hFF; data_B = 8'hFF; data_C = 8'hFF;
    select = 3'b111; instruction = 8'h00;
    tick();
    start = 1'b0; valid = 1'b0;
    beat(8'h01, 8'h02, 8'h03, 3'b111, 8'h00);
    expect_done(8'h02, "start_beats_valid");
    idle(2);

    // Reset mid-operation aborts it and clears the result.
    op_start(3'd2);
    beat(8'h50, 8'h60, 8'h70, 3'b111, 8'h00);
    rst_n = 1'b1;
    tick();
    push_exp(8'h00, cyc, "reset_mid_op");
    rst_n = 1'b0;
    beat(8'h90, 8'h91, 8'h92, 3'b111, 8'h00);
    idle(2);
    op_start(3'd1);
    beat(8'h07, 8'h03, 8'h05, 3'b111, 8'h00);
    expect_done(8'h05, "after_reset");
    idle(3);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d results still pending, required 0", sb.size());
    end
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
